// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped I/O controller for the mini_rv data port.
// Decodes each CPU data access into DRAM space or the I/O register file.
// The I/O registers are the seven-segment data, the LEDs, a debounced switch
// input and a down-counting timer with a sticky expiry flag and an interrupt.
//
// Ports:
//   clk        CPU clock
//   rst        synchronous, active-high reset
//   cpu_addr   data address from the CPU
//   cpu_we     data write enable
//   cpu_wdata  store data
//   cpu_rdata  load data returned to the CPU (combinational)
//   dram_rdata DRAM read data
//   dram_we    DRAM write enable (combinational)
//   switch     raw asynchronous switch inputs
//   seg_data   seven-segment display value
//   led        LED drive
//   timer_irq  level timer interrupt (registered EXP & IE)

module mmio_ctrl #(
  parameter logic [19:0] IO_BASE    = 20'hFFFFF,
  parameter int unsigned DEB_CYCLES = 20000,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic [31:0] dram_rdata,
  output logic        dram_we,
  input  logic [23:0] switch,
  output logic [31:0] seg_data,
  output logic [23:0] led,
  output logic        timer_irq
);

  localparam logic [11:0] OFF_SEG   = 12'h000;
  localparam logic [11:0] OFF_TLOAD = 12'h020;
  localparam logic [11:0] OFF_TCTRL = 12'h024;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;

  // Counter widths are sized to hold the terminal value even when it is 0.
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned PS_W  = $clog2(PRESCALE + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);

  logic        io_sel;
  logic [11:0] offset;
  logic        wr_seg, wr_led, wr_tload, wr_tctrl;

  logic [31:0]      seg_q, seg_d;
  logic [23:0]      led_q, led_d;
  logic [23:0]      sync1_q, sync1_d;
  logic [23:0]      sync2_q, sync2_d;
  logic [23:0]      sw_deb_q, sw_deb_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [31:0]      reload_q, reload_d;
  logic [31:0]      count_q, count_d;
  logic             en_q, en_d;
  logic             auto_q, auto_d;
  logic             exp_q, exp_d;
  logic             ie_q, ie_d;
  logic             irq_q, irq_d;
  logic             tick;

  // Address decode and write strobes.
  always_comb begin
    io_sel   = (cpu_addr[31:12] == IO_BASE);
    offset   = cpu_addr[11:0];
    dram_we  = cpu_we & ~io_sel;
    wr_seg   = cpu_we & io_sel & (offset == OFF_SEG);
    wr_led   = cpu_we & io_sel & (offset == OFF_LED);
    wr_tload = cpu_we & io_sel & (offset == OFF_TLOAD);
    wr_tctrl = cpu_we & io_sel & (offset == OFF_TCTRL);
  end

  // Load data mux; unmapped I/O offsets read as zero.
  always_comb begin
    cpu_rdata = dram_rdata;
    if (io_sel) begin
      case (offset)
        OFF_SEG:   cpu_rdata = seg_q;
        OFF_LED:   cpu_rdata = {8'b0, led_q};
        OFF_SW:    cpu_rdata = {8'b0, sw_deb_q};
        OFF_TLOAD: cpu_rdata = count_q;
        OFF_TCTRL: cpu_rdata = {28'b0, ie_q, exp_q, auto_q, en_q};
        default:   cpu_rdata = 32'b0;
      endcase
    end
  end

  // Output registers.
  always_comb begin
    seg_d = wr_seg ? cpu_wdata : seg_q;
    led_d = wr_led ? cpu_wdata[23:0] : led_q;
  end

  // Switch debounce. A change of the synchronized value (sync1 != sync2)
  // restarts the count so a glitch never accumulates toward acceptance.
  always_comb begin
    sync1_d   = switch;
    sync2_d   = sync1_q;
    sw_deb_d  = sw_deb_q;
    deb_cnt_d = '0;
    if ((sync1_q == sync2_q) && (sync2_q != sw_deb_q)) begin
      if (deb_cnt_q == DEB_LAST) begin
        sw_deb_d  = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Timer. Precedence is built by ordering: the TCTRL write goes first, then
  // the tick may set EXP over a clear, then a TLOAD write overrides count.
  // Expiry only clears EN when no TCTRL write this cycle asks for EN=1.
  always_comb begin
    tick     = en_q && (ps_q == PS_LAST);
    ps_d     = (!en_q || tick) ? '0 : ps_q + 1'b1;
    reload_d = reload_q;
    count_d  = count_q;
    en_d     = en_q;
    auto_d   = auto_q;
    exp_d    = exp_q;
    ie_d     = ie_q;
    if (wr_tctrl) begin
      en_d   = cpu_wdata[0];
      auto_d = cpu_wdata[1];
      ie_d   = cpu_wdata[3];
      if (cpu_wdata[2]) exp_d = 1'b0;
    end
    if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        exp_d = 1'b1;
        if (auto_q) begin
          count_d = reload_q;
        end else begin
          count_d = 32'd0;
          if (!wr_tctrl) en_d = 1'b0;
        end
      end
    end
    if (wr_tload) begin
      reload_d = cpu_wdata;
      count_d  = cpu_wdata;
    end
    irq_d = exp_q & ie_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= '0;
      led_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sw_deb_q  <= '0;
      deb_cnt_q <= '0;
      ps_q      <= '0;
      reload_q  <= '0;
      count_q   <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      exp_q     <= 1'b0;
      ie_q      <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      led_q     <= led_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sw_deb_q  <= sw_deb_d;
      deb_cnt_q <= deb_cnt_d;
      ps_q      <= ps_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      en_q      <= en_d;
      auto_q    <= auto_d;
      exp_q     <= exp_d;
      ie_q      <= ie_d;
      irq_q     <= irq_d;
    end
  end

  assign seg_data  = seg_q;
  assign led       = led_q;
  assign timer_irq = irq_q;

endmodule

// File: doc/mmio_ctrl.md
Name: mmio_ctrl

Overview:
- Memory-mapped I/O controller between the mini_rv data port and the DRAM, seven-segment and LED peripherals.
- Decodes each CPU data access and steers it to the DRAM or the I/O register file.
- Owns the seg-display data register, the LED register, a debounced switch input and a programmable down-counting timer with a sticky expiry flag and an interrupt output.

Parameters:
- IO_BASE, 20'hFFFFF: value of cpu_addr[31:12] that selects I/O space.
- DEB_CYCLES, 20000: consecutive stable cycles required before a switch change is accepted. Minimum 1.
- PRESCALE, 1: timer decrements once every PRESCALE clk cycles. Minimum 1.

Ports:
- clk  in  1  CPU clock (clk_i domain)
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  32  data address (ALU result)
- cpu_we  in  1  data write enable
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data returned to CPU
- dram_rdata  in  32  DRAM read data
- dram_we  out  1  DRAM write enable
- switch  in  24  raw asynchronous switch inputs
- seg_data  out  32  value shown on the seven-segment display
- led  out  24  LED drive
- timer_irq  out  1  timer interrupt, level

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is synchronous, active-high, and named rst.
  - On rst: seg_data=0, led=0, debounced switch=0, sync flops=0, deb counter=0, reload=0, count=0, ctrl=0, timer_irq=0.
  - rst overrides every other action in the same cycle, including a concurrent CPU write.
- Decode:
  - io_sel = (cpu_addr[31:12]==IO_BASE).
  - dram_we = cpu_we & ~io_sel. This path is combinational.
- I/O map (low 12 bits):
  - 0x000 SEG: read/write 32 bits.
  - 0x060 LED: write takes wdata[23:0]. Read returns {8'b0, led}.
  - 0x070 SW: read only, returns {8'b0, debounced switch}. Writes are ignored.
  - 0x020 TLOAD: write sets reload and count. Read returns the current count.
  - 0x024 TCTRL: bit0 EN, bit1 AUTO, bit2 EXP (sticky), bit3 IE. Other bits read 0.
  - All other I/O offsets read 0, and writes to them are dropped.
- Reads:
  - cpu_rdata is combinational in the same cycle.
  - io_sel=0 gives dram_rdata. io_sel=1 gives the mapped register.
- Writes: take effect at the posedge where cpu_we=1 and io_sel=1. They are visible on reads in the next cycle.
- Switch path:
  - 2-flop synchronizer, then compare against the debounced value.
  - While the synced value differs from the debounced value, the counter increments. It resets to 0 on equality or whenever the synced value changes.
  - When the counter reaches DEB_CYCLES-1 with a difference still present, the debounced value takes the synced value and the counter clears.
  - Latency for a clean change is DEB_CYCLES+2 cycles.
- Timer, one tick every PRESCALE cycles while EN=1:
  - Prescaler is free-running only while EN=1, and is cleared when EN=0.
  - On a tick with count>0: count decrements by 1.
  - On a tick with count==0: EXP is set. If AUTO=1, count takes reload. Otherwise EN clears and count stays 0.
- TCTRL write:
  - EN, AUTO and IE take wdata bits.
  - wdata[2]=1 clears EXP. wdata[2]=0 leaves EXP unchanged.
- Simultaneous events:
  - A TLOAD write beats a decrement or reload of count in the same cycle.
  - An expiry set beats an EXP clear in the same cycle, so no event is lost.
  - An expiry that clears EN beats a TCTRL write's EN only if the write sets EN=0. A write with EN=1 keeps the timer running.
- timer_irq = EXP & IE, registered. It is asserted in the cycle after the EXP or IE update.

Test Plan:
- rst for 2 cycles with cpu_we=1 at 0xFFFFF000 -> seg_data=0, led=0, timer_irq=0; next read of 0xFFFFF070 returns 0.
- Write 0x12345678 to 0xFFFFF000, then 0xAABBCCDD to 0xFFFFF060 -> seg_data=0x12345678, led=0xBBCCDD, dram_we=0 both cycles; write to 0x00004000 -> dram_we=1; read 0x00004000 returns dram_rdata.
- DEB_CYCLES=4: switch 0->0x00000F -> SW read 0 through cycle 5, 0x00000F from cycle 6; 2-cycle glitch to 0x0000FF -> no change.
- PRESCALE=1: TLOAD=3, TCTRL=0x9 -> count 3,2,1,0, EXP set on 4th tick, timer_irq=1 the following cycle, EN reads 0; TCTRL write 0x4 -> EXP=0, irq=0.
- TLOAD=2, TCTRL=0xB -> expiry every 3 ticks with count reloading to 2; TCTRL write 0xF in the expiry cycle -> EXP stays 1.
- TLOAD write of 5 in the same cycle as a tick at count=1 -> count reads 5 next cycle.
